// File: rtl/ssd_pkg.sv
// Shared types and helpers for the 2-digit 7-segment scan scheduler.
//   state_e      : scan FSM states (right dead/on, left dead/on)
//   dwell_cycles : per-digit slot length in system clocks
//   DIGIT_W/VALUE_W/BRIGHT_W : payload widths
package ssd_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned VALUE_W  = 2 * DIGIT_W;
    localparam int unsigned BRIGHT_W = 3;

    typedef enum logic [1:0] {
        R_DEAD = 2'd0,
        R_ON   = 2'd1,
        L_DEAD = 2'd2,
        L_ON   = 2'd3
    } state_e;

    // One full frame covers both digits, so each digit gets half of a frame period.
    function automatic int unsigned dwell_cycles(input int unsigned clk_hz,
                                                 input int unsigned scan_hz);
        return clk_hz / (2 * scan_hz);
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Display-value handshake between user logic (master) and the scan scheduler (slave).
//   value : [7:4] left digit, [3:0] right digit
//   valid : value is valid
//   ready : scheduler can accept; transfer when valid & ready
interface ssd_scan_ctrl_if;
    import ssd_pkg::*;

    logic [VALUE_W-1:0] value;
    logic               valid;
    logic               ready;

    modport master (output value, output valid, input ready);
    modport slave  (input value, input valid, output ready);

endinterface

// File: rtl/ssd_pwm.sv
// Brightness PWM for the ON slots: 3-bit counter plus duty compare.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : restart the counter at 0 on the next edge (ON-slot entry)
//   brightness_i   : duty select, 0 = 1/8 .. 7 = 8/8
//   on_o           : lookahead compare for the count loaded at the next edge,
//                    so the parent can register it alongside its state
module ssd_pwm
    import ssd_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
    input  logic [BRIGHT_W-1:0] brightness_i,
    output logic                on_o
);

    logic [BRIGHT_W-1:0] cnt_q;
    logic [BRIGHT_W-1:0] cnt_d;

    // Next count and its duty compare.
    always_comb begin
        cnt_d = cnt_q + BRIGHT_W'(1);
        if (clear_i) begin
            cnt_d = '0;
        end
        on_o = (cnt_d <= brightness_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Scan scheduler for a 2-digit multiplexed 7-segment display.
// Alternates digits with a blanked dead time at the start of each slot,
// applies brightness PWM and optional leading-zero blanking, and commits
// new display values only at frame boundaries so the display never tears.
//   clk_i, reset_i  : clock, synchronous active-high reset
//   in_if           : value/valid/ready handshake (slave side)
//   brightness_i    : 0 = dimmest .. 7 = full on, sampled at frame boundary
//   left_digit_o    : committed left nibble
//   right_digit_o   : committed right nibble
//   digit_sel_o     : 0 = right digit active, 1 = left digit active
//   blank_o         : 1 = segments forced off
//   frame_o         : one-cycle pulse in the first cycle of each committed frame
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned clk_hz_p      = 12000000,
    parameter int unsigned scan_hz_p     = 100,
    parameter int unsigned dead_cycles_p = 64,
    parameter bit          suppress_lz_p = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    ssd_scan_ctrl_if.slave       in_if,
    input  logic [BRIGHT_W-1:0]  brightness_i,
    output logic [DIGIT_W-1:0]   left_digit_o,
    output logic [DIGIT_W-1:0]   right_digit_o,
    output logic                 digit_sel_o,
    output logic                 blank_o,
    output logic                 frame_o
);

    localparam int unsigned DWELL     = dwell_cycles(clk_hz_p, scan_hz_p);
    localparam int unsigned ON_CYCLES = DWELL - dead_cycles_p;
    localparam int unsigned SLOT_W    = (DWELL > 2) ? $clog2(DWELL) : 1;

    if (!(DWELL > dead_cycles_p + 1)) begin : g_bad_timing
        $error("ssd_scan_ctrl: dwell_cycles must exceed dead_cycles_p + 1");
    end

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [VALUE_W-1:0]  pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [VALUE_W-1:0]  shown_q, shown_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic                ready_q, ready_d;
    logic                sel_q, sel_d;
    logic                blank_q, blank_d;
    logic                frame_q, frame_d;

    logic                slot_last;
    logic                commit;
    logic                accept;
    logic                enter_on;
    logic                pwm_on;

    ssd_pwm u_pwm (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (enter_on),
        .brightness_i (bright_d),
        .on_o         (pwm_on)
    );

    // Next-state, handshake, commit and registered-output lookahead.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q + SLOT_W'(1);
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shown_d     = shown_q;
        bright_d    = bright_q;
        frame_d     = 1'b0;
        sel_d       = 1'b0;
        blank_d     = 1'b1;
        enter_on    = 1'b0;

        if (state_q == R_DEAD || state_q == L_DEAD) begin
            slot_last = (slot_q == SLOT_W'(dead_cycles_p - 1));
        end else begin
            slot_last = (slot_q == SLOT_W'(ON_CYCLES - 1));
        end

        if (slot_last) begin
            slot_d = '0;
            unique case (state_q)
                R_DEAD:  state_d = R_ON;
                R_ON:    state_d = L_DEAD;
                L_DEAD:  state_d = L_ON;
                default: state_d = R_DEAD;
            endcase
        end

        commit   = (state_q == L_ON) && slot_last;
        accept   = in_if.valid && ready_q;
        enter_on = (state_d != state_q) && (state_d == R_ON || state_d == L_ON);

        // Commit only moves a full pending slot; accept only fills an empty one,
        // so the two never touch the same data in one cycle.
        if (commit) begin
            frame_d  = 1'b1;
            bright_d = brightness_i;
            if (pend_full_q) begin
                shown_d     = pend_q;
                pend_full_d = 1'b0;
            end
        end
        if (accept) begin
            pend_d      = in_if.value;
            pend_full_d = 1'b1;
        end

        ready_d = !pend_full_d;
        sel_d   = (state_d == L_DEAD) || (state_d == L_ON);

        unique case (state_d)
            R_ON:    blank_d = !pwm_on;
            L_ON:    blank_d = !pwm_on ||
                               (suppress_lz_p && (shown_d[VALUE_W-1 -: DIGIT_W] == '0));
            default: blank_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= R_DEAD;
            slot_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            shown_q     <= '0;
            bright_q    <= BRIGHT_W'(7);
            ready_q     <= 1'b1;
            sel_q       <= 1'b0;
            blank_q     <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            shown_q     <= shown_d;
            bright_q    <= bright_d;
            ready_q     <= ready_d;
            sel_q       <= sel_d;
            blank_q     <= blank_d;
            frame_q     <= frame_d;
        end
    end

    assign in_if.ready   = ready_q;
    assign left_digit_o  = shown_q[VALUE_W-1 -: DIGIT_W];
    assign right_digit_o = shown_q[DIGIT_W-1:0];
    assign digit_sel_o   = sel_q;
    assign blank_o       = blank_q;
    assign frame_o       = frame_q;

endmodule
